// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants, interrupt word field positions and FSM state type for
// the interrupt sequencer.
package intr_pkg;

  localparam logic [1:0] INT_TAG = 2'b10;

  localparam int TAG_HI  = 31;
  localparam int TAG_LO  = 30;
  localparam int PRIO_HI = 29;
  localparam int PRIO_LO = 25;
  localparam int ADDR_HI = 19;
  localparam int ADDR_LO = 0;

  localparam int PRIO_W = 5;
  localparam int ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    DISPATCH = 2'd2,
    SERVICE  = 2'd3
  } state_t;

  function automatic logic is_int_word(input logic [31:0] word);
    return word[TAG_HI:TAG_LO] == INT_TAG;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// CPU-side dispatch handshake. irq_req rises with address/source/priority
// stable and stays high until irq_ack is sampled; irq_done closes service.
interface interrupt_sequencer_if #(
  parameter int SRC_W = 1
);
  logic              irq_req;
  logic [19:0]       irq_address;
  logic [SRC_W-1:0]  irq_source;
  logic [4:0]        irq_priority;
  logic              irq_ack;
  logic              irq_done;

  modport master (
    output irq_req, irq_address, irq_source, irq_priority,
    input  irq_ack, irq_done
  );

  modport slave (
    input  irq_req, irq_address, irq_source, irq_priority,
    output irq_ack, irq_done
  );
endinterface

// File: rtl/interrupt_sequencer_priority_select.sv
// Combinational max-priority picker over the pending slots; on equal
// priority the lowest slot index wins.
module interrupt_priority_select
  import intr_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0]        i_pending,
  input  logic [N_SRC*PRIO_W-1:0] i_prio,
  output logic [SRC_W-1:0]        o_idx,
  output logic                    o_valid
);

  logic [PRIO_W-1:0] w_best;

  // Strict greater-than keeps the earlier (lower) index on ties.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_best  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (i_pending[k] && (!o_valid || i_prio[k*PRIO_W +: PRIO_W] > w_best)) begin
        o_idx   = SRC_W'(k);
        o_valid = 1'b1;
        w_best  = i_prio[k*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Captures tagged interrupt words into pending slots, arbitrates by priority
// and dispatches one handler address at a time under a watchdog.
module interrupt_sequencer
  import intr_pkg::*;
#(
  parameter int N_SRC          = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SRC_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC*32-1:0]   interrupt_in,
  input  logic [N_SRC-1:0]      interrupt_valid,
  input  logic                  interrupt_disable,
  interrupt_sequencer_if.master cpu,
  output logic [N_SRC-1:0]      pending,
  output logic                  irq_timeout,
  output logic                  irq_overrun,
  output logic                  busy,
  output state_t                o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_wd_cnt;
  logic [N_SRC-1:0]    r_pending;
  logic [ADDR_W-1:0]   r_addr [N_SRC];
  logic [PRIO_W-1:0]   r_prio [N_SRC];
  logic                r_req;
  logic [ADDR_W-1:0]   r_irq_addr;
  logic [SRC_W-1:0]    r_irq_src;
  logic [PRIO_W-1:0]   r_irq_prio;
  logic                r_timeout;
  logic                r_overrun;

  logic [31:0]              w_word [N_SRC];
  logic [N_SRC*PRIO_W-1:0]  w_prio_flat;
  logic [N_SRC-1:0]         w_cap;
  logic [N_SRC-1:0]         w_ovr;
  logic [N_SRC-1:0]         w_clr;
  logic [SRC_W-1:0]         w_win_idx;
  logic                     w_win_valid;
  logic                     w_wd_expire;
  logic                     w_ack_clr;
  logic                     w_to_clr;

  // Watchdog fires on the cycle the count would reach TIMEOUT_CYCLES, unless
  // a handshake event for the current state lands in the same cycle.
  always_comb begin
    w_wd_expire = 1'b0;
    if (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      if (r_state == DISPATCH)
        w_wd_expire = !cpu.irq_ack && !interrupt_disable;
      else if (r_state == SERVICE)
        w_wd_expire = !cpu.irq_done;
    end
  end

  assign w_ack_clr = (r_state == DISPATCH) && cpu.irq_ack;
  assign w_to_clr  = (r_state == DISPATCH) && w_wd_expire;

  always_comb begin
    w_clr       = '0;
    w_cap       = '0;
    w_ovr       = '0;
    w_prio_flat = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_word[k] = interrupt_in[32*k +: 32];
      w_prio_flat[k*PRIO_W +: PRIO_W] = r_prio[k];
      if ((w_ack_clr || w_to_clr) && r_irq_src == SRC_W'(k))
        w_clr[k] = 1'b1;
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (interrupt_valid[k] && is_int_word(w_word[k])) begin
        // A slot being released this cycle can take the new word at once.
        if (!r_pending[k] || w_clr[k]) w_cap[k] = 1'b1;
        else                           w_ovr[k] = 1'b1;
      end
    end
  end

  interrupt_priority_select #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_prio_sel (
    .i_pending (r_pending),
    .i_prio    (w_prio_flat),
    .o_idx     (w_win_idx),
    .o_valid   (w_win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_overrun <= 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
        r_addr[k] <= '0;
        r_prio[k] <= '0;
      end
    end else begin
      r_overrun <= |w_ovr;
      for (int k = 0; k < N_SRC; k++) begin
        if (w_cap[k]) begin
          r_addr[k] <= w_word[k][ADDR_HI:ADDR_LO];
          r_prio[k] <= w_word[k][PRIO_HI:PRIO_LO];
        end
        r_pending[k] <= w_cap[k] | (r_pending[k] & ~w_clr[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wd_cnt   <= '0;
      r_req      <= 1'b0;
      r_irq_addr <= '0;
      r_irq_src  <= '0;
      r_irq_prio <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|r_pending && !interrupt_disable) r_state <= ARB;
        end
        ARB: begin
          r_irq_src  <= w_win_idx;
          r_irq_addr <= w_win_valid ? r_addr[w_win_idx] : '0;
          r_irq_prio <= w_win_valid ? r_prio[w_win_idx] : '0;
          r_req      <= 1'b1;
          r_wd_cnt   <= '0;
          r_state    <= DISPATCH;
        end
        DISPATCH: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (cpu.irq_ack) begin
            r_req   <= 1'b0;
            r_state <= SERVICE;
          end else if (interrupt_disable) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else if (w_wd_expire) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end
        end
        SERVICE: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (cpu.irq_done) begin
            r_state <= IDLE;
          end else if (w_wd_expire) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu.irq_req      = r_req;
  assign cpu.irq_address  = r_irq_addr;
  assign cpu.irq_source   = r_irq_src;
  assign cpu.irq_priority = r_irq_prio;
  assign pending          = r_pending;
  assign irq_timeout      = r_timeout;
  assign irq_overrun      = r_overrun;
  assign busy             = (r_state != IDLE);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: capture, arbitration, masking,
// watchdog, overrun and asynchronous reset behaviour.
module tb_interrupt_sequencer;
  import intr_pkg::*;

  localparam int N_SRC = 2;
  localparam int TMO   = 16;
  localparam int SRC_W = 1;

  logic              clk;
  logic              rst_n;
  logic [N_SRC*32-1:0] interrupt_in;
  logic [N_SRC-1:0]  interrupt_valid;
  logic              interrupt_disable;
  logic [N_SRC-1:0]  pending;
  logic              irq_timeout;
  logic              irq_overrun;
  logic              busy;
  state_t            dbg_state;

  interrupt_sequencer_if #(.SRC_W(SRC_W)) cpu_if ();

  interrupt_sequencer #(
    .N_SRC          (N_SRC),
    .TIMEOUT_CYCLES (TMO),
    .SRC_W          (SRC_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .interrupt_in      (interrupt_in),
    .interrupt_valid   (interrupt_valid),
    .interrupt_disable (interrupt_disable),
    .cpu               (cpu_if.master),
    .pending           (pending),
    .irq_timeout       (irq_timeout),
    .irq_overrun       (irq_overrun),
    .busy              (busy),
    .o_dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_word(input logic [1:0] tag, input logic [4:0] prio,
                                          input logic [19:0] addr);
    return {tag, prio, 5'd0, addr};
  endfunction

  // driver tasks
  task automatic strobe(input int k, input logic [31:0] word);
    interrupt_in[32*k +: 32] = word;
    interrupt_valid[k] = 1'b1;
    tick();
    interrupt_valid = '0;
  endtask

  task automatic strobe2(input logic [31:0] w0, input logic [31:0] w1);
    interrupt_in = {w1, w0};
    interrupt_valid = 2'b11;
    tick();
    interrupt_valid = '0;
  endtask

  task automatic ack_done();
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    chk("req_drop_after_ack", 32'(cpu_if.irq_req), 32'd0);
    tick();
    cpu_if.irq_done = 1'b1;
    tick();
    cpu_if.irq_done = 1'b0;
  endtask

  // scoreboard: next dispatched {source, address} comes off exp_q
  task automatic wait_req();
    logic seen;
    logic [31:0] exp;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (cpu_if.irq_req) seen = 1'b1;
    end
    chk("wait_req_timeout", 32'(seen), 32'd1);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      if (seen) chk("dispatch_src_addr", {11'd0, cpu_if.irq_source, cpu_if.irq_address}, exp);
    end
  endtask

  initial begin
    int pulses;
    int pulse_cyc;
    rst_n = 1'b0;
    interrupt_in = '0;
    interrupt_valid = '0;
    interrupt_disable = 1'b0;
    cpu_if.irq_ack = 1'b0;
    cpu_if.irq_done = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(cpu_if.irq_req), 32'd0);
    chk("rst_addr", 32'(cpu_if.irq_address), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {30'd0, irq_timeout, irq_overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // two sources, higher priority first, exact latency
    strobe2(mk_word(2'b10, 5'd3, 20'h00100), mk_word(2'b10, 5'd9, 20'h00200));
    chk("t1_pending", 32'(pending), 32'h3);
    chk("t1_req_t1", 32'(cpu_if.irq_req), 32'd0);
    tick();
    chk("t1_req_t2", 32'(cpu_if.irq_req), 32'd0);
    chk("t1_arb_state", 32'(dbg_state), 32'(ARB));
    tick();
    chk("t1_req_t3", 32'(cpu_if.irq_req), 32'd1);
    chk("t1_addr", 32'(cpu_if.irq_address), 32'h00200);
    chk("t1_src", 32'(cpu_if.irq_source), 32'd1);
    chk("t1_prio", 32'(cpu_if.irq_priority), 32'd9);
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    chk("t1_req_fall", 32'(cpu_if.irq_req), 32'd0);
    chk("t1_pending_after_ack", 32'(pending), 32'h1);
    tick();
    chk("t1_service_hold", 32'(cpu_if.irq_address), 32'h00200);
    cpu_if.irq_done = 1'b1;
    tick();
    cpu_if.irq_done = 1'b0;
    chk("t1_idle_after_done", 32'(busy), 32'd0);
    tick();
    chk("t1_req_u1", 32'(cpu_if.irq_req), 32'd0);
    tick();
    chk("t1_req_u2", 32'(cpu_if.irq_req), 32'd1);
    chk("t1_addr2", 32'(cpu_if.irq_address), 32'h00100);
    chk("t1_src2", 32'(cpu_if.irq_source), 32'd0);
    ack_done();
    chk("t1_pending_end", 32'(pending), 32'd0);

    // equal priority: lowest index first
    strobe2(mk_word(2'b10, 5'd7, 20'h0AAAA), mk_word(2'b10, 5'd7, 20'h0BBBB));
    exp_q.push_back({12'd0, 20'h0AAAA});
    exp_q.push_back({12'd0, 20'h0BBBB} | 32'h0010_0000);
    wait_req();
    ack_done();
    wait_req();
    ack_done();

    // disable during DISPATCH withdraws, keeps pending, then redispatches
    strobe(0, mk_word(2'b10, 5'd4, 20'h12345));
    exp_q.push_back({12'd0, 20'h12345});
    wait_req();
    interrupt_disable = 1'b1;
    tick();
    chk("dis_req_drop", 32'(cpu_if.irq_req), 32'd0);
    chk("dis_pending_kept", 32'(pending), 32'h1);
    tick();
    tick();
    chk("dis_held_idle", 32'(busy), 32'd0);
    interrupt_disable = 1'b0;
    exp_q.push_back({12'd0, 20'h12345});
    wait_req();
    ack_done();

    // watchdog: no ack for TMO cycles
    strobe(1, mk_word(2'b10, 5'd1, 20'h0F00F));
    exp_q.push_back({12'd0, 20'h0F00F} | 32'h0010_0000);
    wait_req();
    pulses = 0;
    pulse_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (irq_timeout) begin
        pulses++;
        pulse_cyc = i;
        chk("tmo_pending_clr", 32'(pending), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_req", 32'(cpu_if.irq_req), 32'd0);
      end
    end
    chk("tmo_pulse_count", 32'(pulses), 32'd1);
    chk("tmo_pulse_cycle", 32'(pulse_cyc), 32'(TMO));

    // overrun and ignored tag, with dispatch masked
    interrupt_disable = 1'b1;
    strobe(0, mk_word(2'b10, 5'd2, 20'h11111));
    chk("ovr_first_none", 32'(irq_overrun), 32'd0);
    strobe(0, mk_word(2'b10, 5'd2, 20'h22222));
    chk("ovr_pulse", 32'(irq_overrun), 32'd1);
    tick();
    chk("ovr_one_cycle", 32'(irq_overrun), 32'd0);
    strobe(1, mk_word(2'b01, 5'd9, 20'h33333));
    chk("tag_ignored_pending", 32'(pending), 32'h1);
    chk("tag_ignored_ovr", 32'(irq_overrun), 32'd0);
    interrupt_disable = 1'b0;
    exp_q.push_back({12'd0, 20'h11111});
    wait_req();

    // ack and re-strobe of the same slot in one cycle
    cpu_if.irq_ack = 1'b1;
    interrupt_in[31:0] = mk_word(2'b10, 5'd1, 20'h04444);
    interrupt_valid = 2'b01;
    tick();
    cpu_if.irq_ack = 1'b0;
    interrupt_valid = '0;
    chk("ackcap_pending", 32'(pending), 32'h1);
    chk("ackcap_no_ovr", 32'(irq_overrun), 32'd0);
    cpu_if.irq_done = 1'b1;
    tick();
    cpu_if.irq_done = 1'b0;
    exp_q.push_back({12'd0, 20'h04444});
    wait_req();
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;

    // asynchronous reset while in SERVICE with work pending
    strobe(1, mk_word(2'b10, 5'd6, 20'h05555));
    chk("rstsvc_state", 32'(dbg_state), 32'(SERVICE));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_outputs", {11'd0, cpu_if.irq_req, cpu_if.irq_source, cpu_if.irq_address}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_idle", {30'd0, busy, cpu_if.irq_req}, 32'd0);
    strobe(1, mk_word(2'b10, 5'd6, 20'h06666));
    exp_q.push_back({12'd0, 20'h06666} | 32'h0010_0000);
    wait_req();
    ack_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequential interrupt controller that captures tagged interrupt instruction words from N sources into pending slots, arbitrates them by 5-bit priority, and dispatches one handler address at a time to the CPU fetch stage through a request/acknowledge/done handshake. It sits between the peripheral interrupt sources and the program-counter load path. It replaces level-sensitive combinational priority selection with a registered, masked, watchdog-protected sequence.

## Interface
- N_SRC, 2: number of interrupt sources (2..8)
- TIMEOUT_CYCLES, 1024: maximum cycles spent in DISPATCH+SERVICE before forced abort
- SRC_W, $clog2(N_SRC) (min 1): source index width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- interrupt_in  in  N_SRC*32  interrupt instruction words, source k at [32k+31:32k]
- interrupt_valid  in  N_SRC  per-source capture strobe, one cycle
- interrupt_disable  in  1  global mask, level
- irq_ack  in  1  CPU accepted irq_address
- irq_done  in  1  CPU finished handler (return)
- irq_req  out  1  dispatch request
- irq_address  out  20  handler address of dispatched source
- irq_source  out  SRC_W  index of dispatched source
- irq_priority  out  5  priority of dispatched source
- pending  out  N_SRC  pending slot flags
- irq_timeout  out  1  one-cycle pulse on watchdog abort
- irq_overrun  out  1  one-cycle pulse when a strobe hits an already-pending slot
- busy  out  1  state is not IDLE

## Operation
- Word format: [31:30]=2'b10 marks an interrupt; [29:25] priority (unsigned, larger wins); [19:0] handler address. Other tags are ignored; no capture, no overrun.
- Capture: valid strobe with tag 10 on a non-pending slot stores address and priority and sets pending. On a pending slot it is dropped and irq_overrun pulses. Exception: if the slot clears on irq_ack in the same cycle, the new word is captured and pending stays 1.
- FSM states are IDLE, ARB, DISPATCH, SERVICE.
- IDLE→ARB when any pending and interrupt_disable=0.
- ARB registers the winner: highest priority, ties go to the lowest index. ARB→DISPATCH always, after 1 cycle.
- DISPATCH: irq_req=1, with irq_address/irq_source/irq_priority held stable.
  - irq_ack → clear that slot's pending, go to SERVICE.
  - interrupt_disable=1 without ack → withdraw the request, go to IDLE, pending is kept.
  - irq_ack and interrupt_disable in the same cycle: ack wins.
- SERVICE: irq_req=0 and outputs are held. irq_done → IDLE. interrupt_disable has no effect. irq_done outside SERVICE is ignored.
- Watchdog: counter clears on ARB→DISPATCH and increments each cycle in DISPATCH/SERVICE.
  - When it reaches TIMEOUT_CYCLES: irq_timeout pulses, the dispatched slot's pending is cleared, state goes to IDLE.
  - A handshake event in the same cycle takes precedence over the timeout.
- No nesting or preemption. A higher-priority capture during SERVICE waits in pending.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE, pending=0, all slot data=0, irq_req=0, irq_address=0, irq_source=0, irq_priority=0, irq_timeout=0, irq_overrun=0, busy=0, counter=0.
- Strobe at edge t → pending visible at t+1 → ARB at t+2 → irq_req=1 at t+3. Minimum latency is 3 cycles.
- irq_req falls the cycle after irq_ack is sampled. Back-to-back: irq_done at edge u gives the next irq_req at u+2 if anything is pending.
- Reset mid-handshake: irq_req drops immediately (async); all pending work is lost.

## Structure
- Package intr_pkg holds:
  - INT_TAG=2'b10
  - field positions TAG_HI/LO, PRIO_HI/LO, ADDR_HI/LO
  - PRIO_W=5, ADDR_W=20
  - state enum: IDLE, ARB, DISPATCH, SERVICE
- Sub-module interrupt_priority_select: combinational N_SRC-way max-priority tree with lowest-index tie-break. Inputs: pending mask and priorities. Outputs: winner index and a valid flag.

## Test plan
- Source0 prio 3 addr 0x00100, source1 prio 9 addr 0x00200, strobed together → irq_req at t+3 with irq_address=0x00200, irq_source=1. After ack+done, second dispatch has 0x00100, irq_source=0.
- Equal prio 7 on both → source0 dispatched first.
- interrupt_disable=1 during DISPATCH → irq_req falls next cycle, pending stays 2'b01. Release → redispatch of the same address.
- No ack for TIMEOUT_CYCLES=16 → irq_timeout pulses exactly once at cycle 16, pending cleared, busy=0.
- Second strobe on pending slot → irq_overrun pulse, stored address unchanged. Strobe with tag 2'b01 → no capture.
- rst_n low during SERVICE → all outputs 0 asynchronously. After release, idle until a new strobe arrives.
